// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the instruction-memory writer and the fetch
// stage: icode constants, error codes, memory geometry and the icode
// property lookup.
package y86_pkg;

  localparam int ADDR_W    = 11;
  localparam int MEM_BYTES = 2048;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ICODE = 2'b01;
  localparam logic [1:0] ERR_OVF   = 2'b10;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  // Field order matches {need_regids, need_valc, legal}.
  typedef struct packed {
    logic need_regids;
    logic need_valc;
    logic legal;
  } icode_info_t;

  function automatic icode_info_t icode_info(input logic [3:0] icode);
    icode_info_t info;
    info = '0;
    case (icode)
      I_HALT, I_NOP, I_RET:               info = '{1'b0, 1'b0, 1'b1};
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:   info = '{1'b1, 1'b0, 1'b1};
      I_JXX, I_CALL:                      info = '{1'b0, 1'b1, 1'b1};
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:       info = '{1'b1, 1'b1, 1'b1};
      default:                            info = '0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/imem_writer_if.sv
// Instruction-load request bus into imem_writer.
//   set_valid/set_addr : write-pointer load request
//   in_valid/in_ready  : instruction handshake
//   icode/ifun/rA/rB/valC : decoded instruction fields
// master = loader driving instructions, slave = imem_writer.
interface imem_writer_if #(
  parameter int ADDR_W = 11
);
  logic              set_valid;
  logic [ADDR_W-1:0] set_addr;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        icode;
  logic [3:0]        ifun;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic [63:0]       valC;

  modport master (
    output set_valid, set_addr, in_valid, icode, ifun, rA, rB, valC,
    input  in_ready
  );

  modport slave (
    input  set_valid, set_addr, in_valid, icode, ifun, rA, rB, valC,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder.sv
// Combinational Y86-64 instruction encoder.
//   icode/ifun/rA/rB/valC : instruction fields
//   bytes : encoded instruction, byte0 in bits [79:72], unused tail zero
//   len   : encoded length in bytes (1, 2, 9 or 10)
//   legal : icode is a defined instruction
module instr_encoder (
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valC,
  output logic [79:0] bytes,
  output logic [3:0]  len,
  output logic        legal
);
  import y86_pkg::*;

  icode_info_t info;

  assign info  = icode_info(icode);
  assign legal = info.legal;
  assign len   = 4'd1 + {3'b000, info.need_regids} + {info.need_valc, 3'b000};

  // valC is laid out most-significant byte first, directly after byte0 or
  // after the register byte.
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves
    // bytes unassigned, which would infer a latch.
    bytes = '0;
    case ({info.need_regids, info.need_valc})
      2'b10:   bytes = {icode, ifun, rA, rB, 64'h0};
      2'b01:   bytes = {icode, ifun, valC, 8'h00};
      2'b11:   bytes = {icode, ifun, rA, rB, valC};
      default: bytes = {icode, ifun, 72'h0};
    endcase
  end

endmodule

// File: rtl/imem_writer.sv
// Instruction encoder/loader: accepts one decoded instruction per handshake
// and writes its encoding one byte per cycle into instruction memory,
// advancing the write pointer as fetch advances the PC.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of the load request bus (set pointer, instruction)
//   wr_en/wr_addr/wr_data : byte write port into instruction memory
//   done       : pulse with the last byte of an instruction
//   err_valid/err_code : pulse on rejection (bad icode / overflow)
//   next_pc    : current write pointer
module imem_writer #(
  parameter int ADDR_W    = 11,
  parameter int MEM_BYTES = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_writer_if.slave      bus,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              done,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] next_pc
);
  import y86_pkg::*;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [79:0]       shreg;
  logic [3:0]        cnt;

  logic [79:0]       enc_bytes;
  logic [3:0]        enc_len;
  logic              enc_legal;
  logic              accept;
  logic [ADDR_W-1:0] base;
  logic              ovf;

  instr_encoder u_enc (
    .icode (bus.icode),
    .ifun  (bus.ifun),
    .rA    (bus.rA),
    .rB    (bus.rB),
    .valC  (bus.valC),
    .bytes (enc_bytes),
    .len   (enc_len),
    .legal (enc_legal)
  );

  // In EMIT, cnt counts bytes still to be written including the one on the
  // port now; cnt == 1 is the final-byte cycle, the only EMIT cycle that can
  // take the next instruction.
  assign bus.in_ready = rst_n &&
                        ((state == S_IDLE) ? !bus.set_valid : (cnt == 4'd1));
  assign accept = bus.in_valid && bus.in_ready;

  // A back-to-back instruction starts after the byte being written now.
  assign base = (state == S_EMIT) ? ptr + ADDR_W'(1) : ptr;
  // One extra bit so base + len can never wrap past the memory end.
  assign ovf  = ({1'b0, base} + (ADDR_W+1)'(enc_len)) > (ADDR_W+1)'(MEM_BYTES);

  assign next_pc = ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      shreg     <= '0;
      cnt       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // reads the pre-edge value regardless of statement order.
      done      <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;

      if (state == S_IDLE && bus.set_valid) begin
        ptr <= bus.set_addr;
      end else if (state == S_EMIT) begin
        ptr <= ptr + ADDR_W'(1);
      end

      if (accept) begin
        if (!enc_legal || ovf) begin
          err_valid <= 1'b1;
          err_code  <= enc_legal ? ERR_OVF : ERR_ICODE;
          wr_en     <= 1'b0;
          state     <= S_IDLE;
        end else begin
          shreg   <= enc_bytes;
          wr_data <= enc_bytes[79:72];
          wr_addr <= base;
          wr_en   <= 1'b1;
          cnt     <= enc_len;
          done    <= (enc_len == 4'd1);
          state   <= S_EMIT;
        end
      end else if (state == S_EMIT && cnt != 4'd1) begin
        shreg   <= shreg << 8;
        wr_data <= shreg[71:64];
        wr_addr <= wr_addr + ADDR_W'(1);
        cnt     <= cnt - 4'd1;
        done    <= (cnt == 4'd2);
      end else begin
        wr_en <= 1'b0;
        state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_imem_writer.sv
module tb_imem_writer;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        done;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [10:0] next_pc;

  imem_writer_if #(.ADDR_W(11)) bus ();

  imem_writer #(.ADDR_W(11), .MEM_BYTES(2048)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .done      (done),
    .err_valid (err_valid),
    .err_code  (err_code),
    .next_pc   (next_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         addr;
    logic [7:0] data;
    logic       last;
  } wr_t;

  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc = 0;
  wr_t        exp_q[$];
  logic [1:0] err_q[$];
  int         ptr_m = 0;
  int         first_wr = -1;
  int         last_wr = -1;
  int         n_wr = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard monitor: every write and every error pulse must match the
  // next expectation produced by the reference model.
  always @(negedge clk) begin
    if (wr_en) begin
      n_wr++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_wr", wr_en, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
        check("done", done, e.last);
      end
    end else if (done) begin
      check("done_no_wr", done, 0);
    end
    if (err_valid) begin
      if (err_q.size() == 0) check("unexpected_err", err_valid, 0);
      else                   check("err_code", err_code, err_q.pop_front());
    end else if (err_code != 2'b00) begin
      check("err_code_idle", err_code, 0);
    end
  end

  // Reference length table straight from the instruction set.
  function automatic int ref_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 0;
    endcase
  endfunction

  task automatic expect_instr(input logic [3:0] ic, input logic [3:0] fn,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [63:0] vc);
    int len;
    int idx;
    logic [7:0] b[10];
    len = ref_len(ic);
    if (len == 0) begin
      err_q.push_back(2'b01);
    end else if (ptr_m + len > MEM_BYTES) begin
      err_q.push_back(2'b10);
    end else begin
      b[0] = {ic, fn};
      idx = 1;
      if (len == 2 || len == 10) begin
        b[idx] = {ra, rb};
        idx++;
      end
      if (len >= 9) begin
        for (int k = 0; k < 8; k++) begin
          b[idx] = 8'(vc >> (56 - 8 * k));
          idx++;
        end
      end
      for (int k = 0; k < len; k++) begin
        wr_t e;
        e.addr = ptr_m + k;
        e.data = b[k];
        e.last = (k == len - 1);
        exp_q.push_back(e);
      end
      ptr_m = (ptr_m + len) % MEM_BYTES;
    end
  endtask

  // Called at posedge+2. Presents the instruction, waits for acceptance and
  // returns at posedge+2 after the accepting edge.
  task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vc, input bit hold);
    bit ok;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.icode = ic;
    bus.ifun  = fn;
    bus.rA    = ra;
    bus.rB    = rb;
    bus.valC  = vc;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("ready_timeout", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #2;
    expect_instr(ic, fn, ra, rb, vc);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && err_q.size() == 0 && !wr_en) begin
        idle = 1;
        break;
      end
    end
    if (!idle) begin
      check("idle_timeout", idle, 1);
      exp_q.delete();
      err_q.delete();
    end
    @(posedge clk);
    #2;
    check("next_pc", next_pc, ptr_m);
  endtask

  task automatic set_ptr(input int a);
    bus.set_valid = 1'b1;
    bus.set_addr  = 11'(a);
    @(posedge clk);
    #2;
    bus.set_valid = 1'b0;
    ptr_m = a;
  endtask

  task automatic clear_stats();
    first_wr = -1;
    last_wr  = -1;
    n_wr     = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.set_valid = 1'b0;
    bus.set_addr  = '0;
    bus.in_valid  = 1'b0;
    bus.icode     = '0;
    bus.ifun      = '0;
    bus.rA        = '0;
    bus.rB        = '0;
    bus.valC      = '0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_done", done, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_next_pc", next_pc, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_wr_addr", wr_addr, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #2;

    // irmovq at pointer 0
    clear_stats();
    issue(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF, 0);
    wait_idle();
    check("irmovq_pc", next_pc, 10);
    check("irmovq_nwr", n_wr, 10);
    check("irmovq_span", last_wr - first_wr + 1, 10);

    // Back-to-back halt, ret, jXX
    set_ptr(0);
    clear_stats();
    issue(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 1);
    issue(4'h9, 4'h0, 4'h0, 4'h0, 64'h0, 1);
    issue(4'h7, 4'h3, 4'h0, 4'h0, 64'h100, 0);
    wait_idle();
    check("b2b_pc", next_pc, 11);
    check("b2b_nwr", n_wr, 11);
    check("b2b_span", last_wr - first_wr + 1, 11);

    // Overflow, then a nop that still fits
    set_ptr(2040);
    clear_stats();
    issue(4'h4, 4'h0, 4'h1, 4'h2, 64'hDEADBEEF, 0);
    wait_idle();
    check("ovf_pc", next_pc, 2040);
    check("ovf_nwr", n_wr, 0);
    issue(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 0);
    wait_idle();
    check("nop_pc", next_pc, 2041);

    // Bad icode
    issue(4'hC, 4'h0, 4'h1, 4'h2, 64'h5, 0);
    wait_idle();

    // set_valid and in_valid together in IDLE: set wins
    clear_stats();
    bus.set_valid = 1'b1;
    bus.set_addr  = 11'd100;
    bus.in_valid  = 1'b1;
    bus.icode     = 4'h1;
    @(negedge clk);
    check("set_blocks_ready", bus.in_ready, 0);
    @(posedge clk);
    #2;
    bus.set_valid = 1'b0;
    bus.in_valid  = 1'b0;
    ptr_m = 100;
    wait_idle();
    check("set_pc", next_pc, 100);
    check("set_nwr", n_wr, 0);

    // Randomized instruction stream
    for (int t = 0; t < 80; t++) begin
      logic [3:0] ic;
      if ($urandom % 5 == 0) begin
        bus.in_valid = 1'b0;
        wait_idle();
        if ($urandom % 2 == 0) set_ptr(2030 + int'($urandom % 18));
        else                   set_ptr(int'($urandom % 2048));
      end
      ic = ($urandom % 8 == 0) ? 4'(12 + $urandom % 4) : 4'($urandom % 12);
      issue(ic, 4'($urandom), 4'($urandom), 4'($urandom),
            {$urandom, $urandom}, bit'($urandom % 2));
    end
    bus.in_valid = 1'b0;
    wait_idle();

    // Reset mid-emission
    set_ptr(500);
    clear_stats();
    issue(4'h3, 4'h0, 4'h4, 4'h5, 64'h1122334455667788, 0);
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    exp_q.delete();
    err_q.delete();
    ptr_m = 0;
    @(negedge clk);
    check("midrst_wr_en", wr_en, 0);
    check("midrst_next_pc", next_pc, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_nwr", n_wr, 3);
    check("midrst_pc_after", next_pc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_writer.md
Name: imem_writer

Overview:
- Instruction encoder and loader: the writer side of the fetch stage's instruction-memory read path.
- Accepts one decoded Y86-64 instruction per handshake (icode, ifun, rA, rB, valC) and packs it into its 1/2/9/10-byte encoding.
- Emits the bytes one per cycle on a byte-wide write port into the 2048-byte instruction memory, advancing an internal write pointer exactly as fetch advances the PC.
- Used by boot/test loaders to populate instruction memory in place of a preloaded image.

Parameters:
- ADDR_W, 11, instruction-memory byte-address width.
- MEM_BYTES, 2048, instruction-memory size in bytes; highest legal address is MEM_BYTES-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- set_valid  input  1  load write pointer from set_addr.
- set_addr  input  ADDR_W  new write-pointer value.
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  block can accept an instruction this cycle.
- icode  input  4  instruction code.
- ifun  input  4  function code.
- rA  input  4  register A field.
- rB  input  4  register B field.
- valC  input  64  constant word.
- wr_en  output  1  memory byte write strobe.
- wr_addr  output  ADDR_W  memory byte address.
- wr_data  output  8  memory byte.
- done  output  1  one-cycle pulse with the last byte of an instruction.
- err_valid  output  1  one-cycle pulse: instruction rejected.
- err_code  output  2  01 = bad icode, 10 = overflow; 00 otherwise.
- next_pc  output  ADDR_W  current write pointer, i.e. the address of the next instruction.

Behaviour:
- Reset (rst_n low at an edge):
  - State returns to IDLE; pointer = 0.
  - wr_en = 0, wr_addr = 0, wr_data = 0, done = 0, err_valid = 0, err_code = 0.
  - in_ready is 0 while rst_n is low.
  - Reset mid-emission abandons the remaining bytes; no further writes occur.
- Length table, indexed by icode:
  - 0 halt, 1 nop, 9 ret: 1 byte.
  - 2 cmovXX, 6 OPq, A pushq, B popq: 2 bytes.
  - 7 jXX, 8 call: 9 bytes.
  - 3 irmovq, 4 rmmovq, 5 mrmovq: 10 bytes.
  - C..F: illegal.
  - Length = 1 + need_regids + 8*need_valC.
- Byte layout:
  - byte0 = {icode, ifun}.
  - If need_regids: byte1 = {rA, rB}.
  - valC follows, most-significant byte first (valC[63:56] at the lowest address). This is the same alignment fetch uses to reassemble valC.
  - For jXX and call, valC starts at byte1.
  - For irmovq, rA is written as given; no forcing to F.
- FSM states:
  - IDLE: in_ready = !set_valid.
  - EMIT: in_ready = 1 only in the cycle carrying the final byte; 0 otherwise.
- Accept occurs at an edge where in_valid && in_ready.
  - Legal, in-range instruction: at that edge latch the encoded bytes into a 10-byte shift register, load the length counter, and go to EMIT.
  - The registered outputs then show wr_en=1, wr_addr=pointer, wr_data=byte0.
- In EMIT, each edge:
  - advances to the next byte, wr_addr+1, pointer+1, counter-1;
  - writes occupy len consecutive cycles starting the cycle after accept.
- done is asserted coincident with the final byte's wr_en.
- After the last byte, next_pc = old pointer + len.
  - An accept in the final-byte cycle starts the next instruction's byte0 in the very next cycle: zero bubbles back-to-back.
  - Otherwise the FSM returns to IDLE with wr_en=0.
- Rejection:
  - Bad icode (C..F): rejected.
  - Overflow (pointer + len > MEM_BYTES): rejected. If both apply, bad icode takes priority.
  - Response: err_valid=1 with err_code in the cycle after accept; no writes; pointer unchanged; state stays IDLE.
- set_valid:
  - Honoured only in IDLE: pointer = set_addr at the edge, and in_ready=0 that cycle, so set wins over a simultaneous in_valid.
  - Ignored in EMIT.
- Pointer arithmetic is ADDR_W bits. The overflow check uses ADDR_W+1 bits so wrap-around never occurs.
- wr_addr and wr_data hold their last values when wr_en=0.

Decomposition:
- Shared package y86_pkg: icode constants (I_HALT..I_POPQ), err_code constants, MEM_BYTES, ADDR_W, and a function returning {need_regids, need_valC, legal} from icode. The fetch stage reuses this function.
- One sub-module, instr_encoder: combinational, from fields to 80-bit byte vector plus length and legal flag.
- The FSM, pointer and shift register stay in imem_writer.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 2 cycles.
  - Required: wr_en=0, done=0, err_valid=0, next_pc=0, in_ready=0; after release, in_ready=1.
- irmovq (icode=3, ifun=0, rA=F, rB=2, valC=0x0123456789ABCDEF) at pointer 0:
  - Required: writes at addr 0..9 of 30,F2,01,23,45,67,89,AB,CD,EF on 10 consecutive cycles; done on the 10th; next_pc=10.
- Back-to-back halt, ret, jXX (ifun=3, valC=0x100) with in_valid held high:
  - Required: addr0=00, addr1=90, addr2..10 = 73,00,00,00,00,00,00,01,00; no idle cycles between writes; next_pc=11.
- Overflow:
  - Stimulus: set_addr=2040, then rmmovq.
  - Required: err_valid=1, err_code=10, no wr_en, next_pc=2040.
  - Follow-up: nop is then written as 10 at addr 2040; next_pc=2041.
- Bad icode:
  - Stimulus: icode=C, and simultaneously set_valid with in_valid in IDLE.
  - Required: the icode=C instruction gives err_code=01 and no writes; in the simultaneous case the pointer loads and the instruction is not accepted (in_ready=0).
- Reset mid-emission:
  - Stimulus: rst_n=0 after 3 bytes of an irmovq.
  - Required: wr_en=0 the following cycle, next_pc=0, no further writes after release.
